// File: rtl/bus_arbiter_if.sv
// Bundle of the fetch port, data port and external bus pins shared by the
// arbiter and its clients. The arbiter sits on the master modport; the CPU
// ports and bus model sit on the slave modport.
interface bus_arbiter_if;
  logic       f_req;
  logic [7:0] f_addr;
  logic       f_ack;
  logic       d_req;
  logic       d_we;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_ack;
  logic [7:0] rdata;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       rom_ram;
  logic       addr_data;
  logic       bus_we;
  logic       busy;

  modport master (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, bus_in,
    output f_ack, d_ack, rdata, bus_out, rom_ram, addr_data, bus_we, busy
  );

  modport slave (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, bus_in,
    input  f_ack, d_ack, rdata, bus_out, rom_ram, addr_data, bus_we, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and phase sequencer for the shared 8-bit memory bus.
// Each granted request runs ADDR, WAIT_CYCLES wait states, DATA, then one
// ack/turnaround cycle in IDLE during which new requests are ignored.
module bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t     state;
  logic       last_grant;
  logic [3:0] wait_cnt;
  logic [7:0] lat_addr;
  logic [7:0] lat_wdata;
  logic       lat_we;
  logic       grant_data;

  // Data wins if it is the only requester, or on a tie when fetch went last.
  assign grant_data = bus.d_req && (!bus.f_req || !last_grant);

  // Single sequencer: all bus outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      wait_cnt      <= 4'd0;
      lat_addr      <= 8'd0;
      lat_wdata     <= 8'd0;
      lat_we        <= 1'b0;
      bus.f_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.rdata     <= 8'd0;
      bus.bus_out   <= 8'd0;
      bus.rom_ram   <= 1'b0;
      bus.addr_data <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.f_ack     <= 1'b0;
          bus.d_ack     <= 1'b0;
          bus.bus_out   <= 8'd0;
          bus.addr_data <= 1'b0;
          bus.bus_we    <= 1'b0;
          bus.busy      <= 1'b0;
          if (!bus.f_ack && !bus.d_ack && (bus.f_req || bus.d_req)) begin
            state         <= ADDR;
            last_grant    <= grant_data;
            lat_addr      <= grant_data ? bus.d_addr : bus.f_addr;
            lat_we        <= grant_data && bus.d_we;
            lat_wdata     <= bus.d_wdata;
            bus.rom_ram   <= grant_data;
            bus.bus_out   <= grant_data ? bus.d_addr : bus.f_addr;
            bus.addr_data <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end
        ADDR: begin
          bus.addr_data <= 1'b0;
          if (WAIT_CYCLES > 0) begin
            state    <= WAIT;
            wait_cnt <= WAIT_LOAD;
          end else begin
            state      <= DATA;
            bus.bus_we <= lat_we;
            if (lat_we) bus.bus_out <= lat_wdata;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state      <= DATA;
            bus.bus_we <= lat_we;
            if (lat_we) bus.bus_out <= lat_wdata;
          end
        end
        DATA: begin
          state       <= IDLE;
          bus.bus_out <= 8'd0;
          bus.bus_we  <= 1'b0;
          bus.busy    <= 1'b0;
          bus.f_ack   <= !bus.rom_ram;
          bus.d_ack   <= bus.rom_ram;
          if (!lat_we) bus.rdata <= bus.bus_in;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: two arbiters (WAIT_CYCLES = 1 and 0) driven by random
// requesters and compared every cycle against a transaction-schedule model.
module tb_bus_arbiter;

  typedef struct packed {
    logic [7:0] bus_out;
    logic       addr_data;
    logic       rom_ram;
    logic       bus_we;
    logic       busy;
    logic       f_ack;
    logic       d_ack;
  } ent_t;

  logic clk;
  logic reset;

  bus_arbiter_if bif1();
  bus_arbiter_if bif0();

  bus_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bif1));
  bus_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bif0));

  int check_cnt;
  int err_cnt;
  int cyc;

  // Requester / bus-model state per instance (index 1: WAIT=1, index 0: WAIT=0)
  logic       f_req_v   [2];
  logic [7:0] f_addr_v  [2];
  logic       d_req_v   [2];
  logic       d_we_v    [2];
  logic [7:0] d_addr_v  [2];
  logic [7:0] d_wdata_v [2];
  logic [7:0] bus_in_v  [2];
  logic       rand_bus;

  // Reference model: position inside the current transaction schedule
  int         pos_m      [2];
  logic       last_gnt_m [2];
  logic       tgt_m      [2];
  logic       we_m       [2];
  logic [7:0] addr_m     [2];
  logic [7:0] wdata_m    [2];
  logic [7:0] rdata_m    [2];
  int         last_ack   [2];

  always #5 clk = ~clk;

  function automatic int waitOf(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i);
    if (i == 1) begin
      bif1.f_req = f_req_v[1]; bif1.f_addr = f_addr_v[1];
      bif1.d_req = d_req_v[1]; bif1.d_we = d_we_v[1];
      bif1.d_addr = d_addr_v[1]; bif1.d_wdata = d_wdata_v[1];
      bif1.bus_in = bus_in_v[1];
    end else begin
      bif0.f_req = f_req_v[0]; bif0.f_addr = f_addr_v[0];
      bif0.d_req = d_req_v[0]; bif0.d_we = d_we_v[0];
      bif0.d_addr = d_addr_v[0]; bif0.d_wdata = d_wdata_v[0];
      bif0.bus_in = bus_in_v[0];
    end
  endtask

  function automatic ent_t sampleDut(input int i);
    ent_t e;
    if (i == 1)
      e = '{bif1.bus_out, bif1.addr_data, bif1.rom_ram, bif1.bus_we, bif1.busy, bif1.f_ack, bif1.d_ack};
    else
      e = '{bif0.bus_out, bif0.addr_data, bif0.rom_ram, bif0.bus_we, bif0.busy, bif0.f_ack, bif0.d_ack};
    return e;
  endfunction

  function automatic logic [7:0] sampleRdata(input int i);
    return (i == 1) ? bif1.rdata : bif0.rdata;
  endfunction

  // Expected pins from the schedule: 1 = ADDR, 2..1+W = WAIT, 2+W = DATA,
  // 3+W = ack cycle, 4+W = turnaround idle, 0 = idle with nothing granted.
  function automatic ent_t expectEnt(input int i);
    ent_t e;
    int   w;
    w = waitOf(i);
    e = '0;
    e.rom_ram = tgt_m[i];
    if (pos_m[i] == 1) begin
      e.bus_out = addr_m[i]; e.addr_data = 1'b1; e.busy = 1'b1;
    end else if (pos_m[i] >= 2 && pos_m[i] < 2 + w) begin
      e.bus_out = addr_m[i]; e.busy = 1'b1;
    end else if (pos_m[i] == 2 + w) begin
      e.bus_out = we_m[i] ? wdata_m[i] : addr_m[i];
      e.bus_we  = we_m[i];
      e.busy    = 1'b1;
    end else if (pos_m[i] == 3 + w) begin
      e.f_ack = !tgt_m[i];
      e.d_ack = tgt_m[i];
    end
    return e;
  endfunction

  task automatic modelReset(input int i);
    pos_m[i] = 0; last_gnt_m[i] = 1'b1; tgt_m[i] = 1'b0;
    we_m[i] = 1'b0; addr_m[i] = 8'd0; wdata_m[i] = 8'd0; rdata_m[i] = 8'd0;
  endtask

  // Advance the model across one rising edge using the inputs present at it.
  task automatic modelStep(input int i);
    int   w;
    logic g;
    w = waitOf(i);
    if (pos_m[i] == 2 + w && !we_m[i]) rdata_m[i] = bus_in_v[i];
    if (pos_m[i] != 0 && pos_m[i] < 4 + w) begin
      pos_m[i]++;
    end else begin
      pos_m[i] = 0;
      if (f_req_v[i] || d_req_v[i]) begin
        g = d_req_v[i] && (!f_req_v[i] || !last_gnt_m[i]);
        last_gnt_m[i] = g;
        tgt_m[i]      = g;
        addr_m[i]     = g ? d_addr_v[i] : f_addr_v[i];
        we_m[i]       = g && d_we_v[i];
        wdata_m[i]    = d_wdata_v[i];
        pos_m[i]      = 1;
      end
    end
  endtask

  // mode 0: hold and drop on ack; 1: random; 2: always requesting; 3: raw random
  task automatic driveClients(input int i, input int mode, input ent_t e);
    if (mode == 3) begin
      f_req_v[i] = 1'($urandom); f_addr_v[i] = 8'($urandom);
      d_req_v[i] = 1'($urandom); d_we_v[i] = 1'($urandom);
      d_addr_v[i] = 8'($urandom); d_wdata_v[i] = 8'($urandom);
    end else begin
      if (e.f_ack) begin
        if (mode == 2 || (mode == 1 && $urandom_range(1) == 1)) f_addr_v[i] = 8'($urandom);
        else f_req_v[i] = 1'b0;
      end else if (mode == 1 && !f_req_v[i] && $urandom_range(2) == 0) begin
        f_req_v[i] = 1'b1; f_addr_v[i] = 8'($urandom);
      end
      if (e.d_ack) begin
        if (mode == 2 || (mode == 1 && $urandom_range(1) == 1)) begin
          d_addr_v[i] = 8'($urandom); d_wdata_v[i] = 8'($urandom); d_we_v[i] = 1'($urandom);
        end else d_req_v[i] = 1'b0;
      end else if (mode == 1 && !d_req_v[i] && $urandom_range(2) == 0) begin
        d_req_v[i] = 1'b1; d_we_v[i] = 1'($urandom);
        d_addr_v[i] = 8'($urandom); d_wdata_v[i] = 8'($urandom);
      end
    end
    if (rand_bus) bus_in_v[i] = 8'($urandom);
    applyStimulus(i);
  endtask

  task automatic runCycles(input int n, input int mode);
    ent_t exp_e, obs_e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!reset) modelReset(i); else modelStep(i);
        exp_e = expectEnt(i);
        obs_e = sampleDut(i);
        checkOutput($sformatf("bus_out[w%0d]", waitOf(i)), 32'(obs_e.bus_out), 32'(exp_e.bus_out));
        checkOutput($sformatf("ctrl[w%0d]", waitOf(i)), 32'(obs_e[5:0]), 32'(exp_e[5:0]));
        checkOutput($sformatf("rdata[w%0d]", waitOf(i)), 32'(sampleRdata(i)), 32'(rdata_m[i]));
        if (mode == 2 && (obs_e.f_ack || obs_e.d_ack)) begin
          if (last_ack[i] >= 0)
            checkOutput($sformatf("ack_gap[w%0d]", waitOf(i)), 32'(cyc - last_ack[i]), 32'(4 + waitOf(i)));
          last_ack[i] = cyc;
        end
        driveClients(i, mode, exp_e);
      end
    end
  endtask

  task automatic clearClients();
    for (int i = 0; i < 2; i++) begin
      f_req_v[i] = 1'b0; d_req_v[i] = 1'b0; d_we_v[i] = 1'b0;
      f_addr_v[i] = 8'd0; d_addr_v[i] = 8'd0; d_wdata_v[i] = 8'd0; bus_in_v[i] = 8'd0;
      applyStimulus(i);
    end
  endtask

  // Reset with random inputs on the pins, then release cleanly.
  task automatic doReset(input int n);
    reset = 1'b0;
    runCycles(n, 3);
    clearClients();
    runCycles(1, 0);
    reset = 1'b1;
  endtask

  initial begin
    ent_t obs_e;
    logic found;
    clk = 1'b0; reset = 1'b0; rand_bus = 1'b1;
    check_cnt = 0; err_cnt = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      modelReset(i);
      last_ack[i] = -1;
    end
    clearClients();

    $display("[TB] reset with random inputs");
    doReset(5);
    runCycles(3, 0);

    $display("[TB] directed fetch read 0x12, bus_in 0xA5");
    rand_bus = 1'b0;
    for (int i = 0; i < 2; i++) begin
      f_req_v[i] = 1'b1; f_addr_v[i] = 8'h12; bus_in_v[i] = 8'hA5; applyStimulus(i);
    end
    runCycles(8, 0);

    $display("[TB] directed write 0x3C to 0x40");
    rand_bus = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d_req_v[i] = 1'b1; d_we_v[i] = 1'b1; d_addr_v[i] = 8'h40; d_wdata_v[i] = 8'h3C; applyStimulus(i);
    end
    runCycles(8, 0);

    $display("[TB] both ports requesting continuously from reset");
    doReset(2);
    for (int i = 0; i < 2; i++) begin
      f_req_v[i] = 1'b1; f_addr_v[i] = 8'($urandom);
      d_req_v[i] = 1'b1; d_we_v[i] = 1'($urandom);
      d_addr_v[i] = 8'($urandom); d_wdata_v[i] = 8'($urandom);
      applyStimulus(i);
      last_ack[i] = -1;
    end
    runCycles(40, 2);

    $display("[TB] random traffic");
    runCycles(2000, 1);
    runCycles(30, 0);

    $display("[TB] reset during WAIT of a write");
    clearClients();
    d_req_v[1] = 1'b1; d_we_v[1] = 1'b1; d_addr_v[1] = 8'h77; d_wdata_v[1] = 8'h99;
    applyStimulus(1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      runCycles(1, 0);
      if (pos_m[1] == 2 && we_m[1]) found = 1'b1;
    end
    checkOutput("reach_wait", 32'(found), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      modelReset(i);
      obs_e = sampleDut(i);
      checkOutput($sformatf("async_outs[w%0d]", waitOf(i)), 32'(obs_e), 32'd0);
      checkOutput($sformatf("async_rdata[w%0d]", waitOf(i)), 32'(sampleRdata(i)), 32'd0);
    end
    clearClients();
    runCycles(2, 0);
    reset = 1'b1;
    d_req_v[1] = 1'b1; d_we_v[1] = 1'b1; d_addr_v[1] = 8'h55; d_wdata_v[1] = 8'hC3;
    applyStimulus(1);
    runCycles(8, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
